// File: rtl/i2s_ns0921_pkg.sv
// NS0921 I2S clock generator: config register encoding
// and controller state shared by the rate-config master.
package i2s_ns0921_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK_A,
    ST_DATA,
    ST_ACK_D,
    ST_STOP,
    ST_GAP
  } state_e;

  localparam logic [3:0] RATE_CODE_MAX = 4'd12;

  // Bit 7 of the config byte gates the MCLK pass-through output
  localparam int CFG_MCLK_BIT = 7;

  localparam logic [7:0] RATE_TABLE [13] = '{
    8'h73, 8'h6F, 8'h2F, 8'h6B,
    8'h0F, 8'h4B, 8'h2B, 8'h0B,
    8'h27, 8'h07, 8'h43, 8'h23,
    8'h00
  };

  function automatic logic [7:0] cfg_encode(
    logic [3:0] code,
    logic       mclk
  );
    logic [7:0] b;
    b = '0;
    if (code <= RATE_CODE_MAX) b = RATE_TABLE[code];
    b[CFG_MCLK_BIT] = b[CFG_MCLK_BIT] | mclk;
    return b;
  endfunction

endpackage

// File: rtl/i2s_rate_cfg_master_qtick.sv
// SCL quarter-period tick generator with stretch hold.
// Hold is honoured once the synchronizer lag has elapsed in the quarter.
module i2c_qtick #(
  parameter int CLK_DIV = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] LAG  = (CLK_DIV > 2) ? 8'd2 : 8'd1;

  logic [7:0] cnt_q, cnt_d;
  logic       stall;

  assign stall  = hold_i && (cnt_q == LAG);
  assign tick_o = !stall && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clr_i || tick_o) cnt_d = '0;
    else if (stall)      cnt_d = cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2s_rate_cfg_master.sv
// Write-only I2C master that loads the NS0921 config register
// from a 4-bit sample-rate code, with NACK retry.
module i2s_rate_cfg_master
  import i2s_ns0921_pkg::*;
#(
  parameter int         CLK_DIV    = 64,
  parameter logic [6:0] SLAVE_ADDR = 7'h41,
  parameter int         RETRIES    = 2
) (
  input  logic       mclk_in,
  input  logic       rst_n,
  input  logic       req,
  input  logic [3:0] rate_sel,
  input  logic       mclk_en,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] cfg_byte
);

  state_e     state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] data_q, data_d;
  logic [2:0] try_q, try_d;
  logic       nack_q, nack_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] cfg_q, cfg_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;
  logic       scl_s1_q, scl_s_q;
  logic       sda_s1_q, sda_s_q;
  logic       tick, last, hold;

  // {scl_oe, sda_oe} for a given state/quarter and current shift bit
  function automatic logic [1:0] line_drive(
    state_e     s,
    logic [1:0] q,
    logic       b
  );
    logic lo;
    lo = (q < 2'd2);
    unique case (s)
      ST_START:           return {q == 2'd3, q != 2'd0};
      ST_ADDR, ST_DATA:   return {lo, !b};
      ST_ACK_A, ST_ACK_D: return {lo, 1'b0};
      ST_STOP:            return {lo, q != 2'd3};
      default:            return 2'b00;
    endcase
  endfunction

  assign hold = (qtr_q == 2'd2) && !scl_s_q &&
                (state_q != ST_IDLE) && (state_q != ST_GAP);

  i2c_qtick #(
    .CLK_DIV(CLK_DIV)
  ) u_qtick (
    .clk_i (mclk_in),
    .rst_ni(rst_n),
    .clr_i (state_q == ST_IDLE),
    .hold_i(hold),
    .tick_o(tick)
  );

  assign last = tick && (qtr_q == 2'd3);

  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    try_d   = try_q;
    nack_d  = nack_q;
    cfg_d   = cfg_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (tick && state_q != ST_IDLE) qtr_d = qtr_q + 2'd1;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (rate_sel > RATE_CODE_MAX) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_START;
            data_d  = cfg_encode(rate_sel, mclk_en);
            try_d   = 3'(RETRIES);
            nack_d  = 1'b0;
            qtr_d   = 2'd0;
          end
        end
      end
      ST_START: begin
        if (last) begin
          state_d = ST_ADDR;
          sh_d    = {SLAVE_ADDR, 1'b0};
          bit_d   = 3'd0;
        end
      end
      ST_ADDR, ST_DATA: begin
        if (last) begin
          sh_d  = {sh_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7)
            state_d = (state_q == ST_ADDR) ? ST_ACK_A : ST_ACK_D;
        end
      end
      ST_ACK_A, ST_ACK_D: begin
        if (tick && qtr_q == 2'd2) nack_d = sda_s_q;
        if (last) begin
          if (state_q == ST_ACK_A && !nack_q) begin
            state_d = ST_DATA;
            sh_d    = data_q;
            bit_d   = 3'd0;
          end else begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (last) begin
          if (!nack_q) begin
            done_d  = 1'b1;
            cfg_d   = data_q;
            state_d = ST_IDLE;
          end else if (try_q != 3'd0) begin
            state_d = ST_GAP;
            try_d   = try_q - 3'd1;
            bit_d   = 3'd0;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = ST_START;
            nack_d  = 1'b0;
            qtr_d   = 2'd0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    {scl_oe_d, sda_oe_d} = line_drive(state_d, qtr_d, sh_d[7]);
  end

  always_ff @(posedge mclk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      qtr_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      data_q   <= '0;
      try_q    <= '0;
      nack_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cfg_q    <= '0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      scl_s1_q <= 1'b1;
      scl_s_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      data_q   <= data_d;
      try_q    <= try_d;
      nack_q   <= nack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cfg_q    <= cfg_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      scl_s1_q <= scl_in;
      scl_s_q  <= scl_s1_q;
      sda_s1_q <= sda_in;
      sda_s_q  <= sda_s1_q;
    end
  end

  assign scl_oe   = scl_oe_q;
  assign sda_oe   = sda_oe_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign cfg_byte = cfg_q;

endmodule

// File: tb/tb_i2s_rate_cfg_master.sv
// Bench for i2s_rate_cfg_master: I2C slave model plus an
// in-order scoreboard of bus events and done/err responses.
module tb_i2s_rate_cfg_master;

  localparam int K_START = 0;
  localparam int K_BYTE  = 1;
  localparam int K_DONE  = 2;
  localparam int K_ERR   = 3;

  typedef struct {
    int kind;
    int val;
    int lat;
  } exp_t;

  exp_t sbq[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       mclk_en = 1'b0;
  logic [3:0] rate_sel = 4'd0;
  logic       scl_oe, sda_oe, busy, done, err;
  logic [7:0] cfg_byte;
  logic       slv_sda = 1'b0;
  int         hold_cnt = 0;
  wire        scl_line;
  wire        sda_line;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int req_cyc = 0;
  int resp_cnt = 0;
  int base_resp = 0;
  bit nack_addr = 1'b0;
  bit stretch_en = 1'b0;

  int         bitn = 0;
  int         byte_idx = 0;
  logic [7:0] rx = 8'h00;
  logic       prev_sc = 1'b1;
  logic       prev_sd = 1'b1;
  logic       prev_sclo = 1'b0;

  assign scl_line = !(scl_oe || (hold_cnt != 0));
  assign sda_line = !(sda_oe || slv_sda);

  i2s_rate_cfg_master #(
    .CLK_DIV   (4),
    .SLAVE_ADDR(7'h41),
    .RETRIES   (2)
  ) dut (
    .mclk_in (clk),
    .rst_n   (rst_n),
    .req     (req),
    .rate_sel(rate_sel),
    .mclk_en (mclk_en),
    .scl_in  (scl_line),
    .sda_in  (sda_line),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .cfg_byte(cfg_byte)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input int v, input int l);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.lat  = l;
    sbq.push_back(e);
  endtask

  task automatic pop_chk(input int k, input int v, input int l);
    exp_t e;
    if (sbq.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected event: got kind %0d val 0x%0h want none", k, v);
      return;
    end
    e = sbq.pop_front();
    chk("event kind", k, e.kind);
    if (e.kind == K_BYTE || e.kind == K_DONE) chk("event value", v, e.val);
    if (e.kind >= K_DONE) chk("response latency", l, e.lat);
  endtask

  // Slave and monitor: decodes START/STOP/bits, drives ACK and stretch
  always @(negedge clk) begin
    logic sc, sd;
    if (hold_cnt != 0) hold_cnt--;
    if (stretch_en && byte_idx == 1 && bitn == 4 && prev_sclo && !scl_oe) begin
      hold_cnt   = 50;
      stretch_en = 1'b0;
    end
    sc = !(scl_oe || (hold_cnt != 0));
    sd = !(sda_oe || slv_sda);
    if (rst_n) begin
      if (prev_sc && sc && prev_sd && !sd) begin
        pop_chk(K_START, 0, 0);
        bitn     = 0;
        byte_idx = 0;
      end else if (prev_sc && sc && !prev_sd && sd) begin
        bitn = 0;
      end else if (!prev_sc && sc) begin
        bitn++;
        if (bitn <= 8) rx = {rx[6:0], sd};
        if (bitn == 8) begin
          pop_chk(K_BYTE, int'(rx), 0);
          byte_idx++;
        end
      end else if (prev_sc && !sc) begin
        if (bitn == 8 && !(nack_addr && byte_idx == 1)) begin
          slv_sda = 1'b1;
        end else if (bitn == 9) begin
          slv_sda = 1'b0;
          bitn    = 0;
        end
      end
      if (done) begin
        pop_chk(K_DONE, int'(cfg_byte), cyc - req_cyc);
        chk("busy low with done", int'(busy), 0);
        resp_cnt++;
      end
      if (err) begin
        pop_chk(K_ERR, 0, cyc - req_cyc);
        chk("busy low with err", int'(busy), 0);
        resp_cnt++;
      end
    end
    prev_sc   = sc;
    prev_sd   = sd;
    prev_sclo = scl_oe;
  end

  task automatic send(input logic [3:0] code, input logic mc);
    @(posedge clk);
    #1;
    base_resp = resp_cnt;
    rate_sel  = code;
    mclk_en   = mc;
    req       = 1'b1;
    req_cyc   = cyc;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic wait_resp(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (resp_cnt != base_resp) break;
      @(posedge clk);
    end
    #1;
    chk("response arrived", int'(resp_cnt != base_resp), 1);
    repeat (4) @(posedge clk);
  endtask

  task automatic xact(
    input logic [3:0] code,
    input logic       mc,
    input int         b,
    input int         lat
  );
    push(K_START, 0, 0);
    push(K_BYTE, 'h82, 0);
    push(K_BYTE, b, 0);
    push(K_DONE, b, lat);
    send(code, mc);
    wait_resp(lat + 100);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset scl_oe", int'(scl_oe), 0);
    chk("reset sda_oe", int'(sda_oe), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset err", int'(err), 0);
    chk("reset cfg_byte", int'(cfg_byte), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    xact(4'd4, 1'b0, 'h0F, 321);
    chk("cfg after code 4", int'(cfg_byte), 'h0F);
    xact(4'd6, 1'b1, 'hAB, 321);
    chk("cfg after code 6", int'(cfg_byte), 'hAB);

    push(K_ERR, 0, 1);
    send(4'd14, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("code 14 bus idle", int'({busy, scl_oe, sda_oe}), 0);
      @(posedge clk);
      #1;
    end
    wait_resp(50);

    nack_addr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(K_START, 0, 0);
      push(K_BYTE, 'h82, 0);
    end
    push(K_ERR, 0, 593);
    send(4'd3, 1'b0);
    wait_resp(800);
    nack_addr = 1'b0;
    chk("cfg kept after nack", int'(cfg_byte), 'hAB);

    stretch_en = 1'b1;
    xact(4'd9, 1'b0, 'h07, 371);
    chk("stretch applied", int'(stretch_en), 0);

    xact(4'd12, 1'b0, 'h00, 321);
    xact(4'd11, 1'b1, 'hA3, 321);

    push(K_ERR, 0, 1);
    send(4'd13, 1'b0);
    wait_resp(50);

    push(K_START, 0, 0);
    push(K_BYTE, 'h82, 0);
    send(4'd10, 1'b0);
    repeat (199) @(posedge clk);
    #1;
    chk("scl low before abort", int'(scl_oe), 1);
    rst_n = 1'b0;
    #1;
    chk("oe released on reset", int'({scl_oe, sda_oe}), 0);
    chk("busy cleared on reset", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("cfg cleared on reset", int'(cfg_byte), 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    xact(4'd0, 1'b0, 'h73, 321);
    chk("cfg after code 0", int'(cfg_byte), 'h73);

    chk("scoreboard drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
